btb_set_assoc: RTL and testbench
================================

Name: btb_set_assoc

Overview:
- N-way set-associative branch target buffer with per-entry saturating direction counters. Generalises the direct-mapped 2-bit BTB.
- Sits between fetch and execute:
  - fetch does a combinational lookup on the current PC;
  - execute writes back the resolved branch outcome one entry per cycle.
- Adds behaviour the direct-mapped BTB lacks:
  - configurable ways and counter width;
  - round-robin victim selection per set;
  - target correction on a hit;
  - a sequential invalidate/flush walker.

Parameters:
- BTB_ENTRIES, 64, total entries; power of two; must be at least BTB_WAYS.
- BTB_WAYS, 2, associativity; power of two, 1..8.
- TARGET_WIDTH, 32, stored target width.
- COUNTER_WIDTH, 2, saturating direction counter width; allowed range 1..4.
- SETS, BTB_ENTRIES/BTB_WAYS, derived.
- INDEX_WIDTH, $clog2(SETS), derived.
- TAG_WIDTH, 30-INDEX_WIDTH, derived; tag = PC[31:INDEX_WIDTH+2].

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- flush  in  1  one-cycle pulse; invalidates the whole BTB.
- ready  out  1  high when the init walker is idle.
- fetchPc  in  32  fetch-stage PC.
- fetchHit  out  1  predicted-taken hit.
- fetchTarget  out  TARGET_WIDTH  predicted target.
- exBranch  in  1  resolved conditional/unconditional branch valid this cycle.
- exTaken  in  1  resolved direction.
- exPc  in  32  PC of the resolved branch.
- exTarget  in  TARGET_WIDTH  resolved target.
- statLookups, statHits, statMispredicts  out  32 each  present only with BTB_STATS_EN.

Behaviour:
- Reset and clock: rst is synchronous, active-low; clk is the clock.

Addressing:
- index = PC[INDEX_WIDTH+1:2].
- Entry fields: valid, tag, target, counter.

Init walker:
- Two-state FSM: IDLE, INIT.
- rst low forces INIT, walkIdx = 0, ready = 0, stat counters = 0.
- In INIT:
  - one set per cycle: all ways' valid bits cleared, and the set's victim pointer cleared;
  - walkIdx increments;
  - after set SETS-1, go to IDLE next cycle.
  - INIT lasts exactly SETS cycles after rst deasserts.
- flush in IDLE enters INIT at walkIdx = 0. flush during INIT restarts at walkIdx = 0.
- While ready = 0: fetchHit = 0, fetchTarget = 0, and all exBranch updates are dropped.

Lookup (combinational, same cycle):
- A way hits when valid && tag match.
- If several ways match, the lowest way index wins. Allocation never creates duplicates.
- fetchHit = hit && counter MSB.
- fetchTarget = the hit way's target; 0 when there is no hit.
- A same-cycle write to the same set is not visible; lookup sees pre-edge contents.

Update (posedge, when ready && exBranch):
- Hit:
  - counter saturating increment if taken, decrement if not taken; clamps at all-ones / zero.
  - If taken and the stored target != exTarget, overwrite the target.
- Miss and taken: allocate.
  - Victim = lowest-index invalid way; otherwise the set's round-robin pointer.
  - Write valid = 1, tag, target, counter = 1<<(COUNTER_WIDTH-1) (weakly taken).
  - The pointer advances (mod BTB_WAYS) only when the pointer way was used.
- Miss and not taken: no change.
- exBranch low: exTaken, exPc and exTarget are ignored.
- BTB_WAYS = 1 degenerates to direct-mapped; the victim pointer is constant 0.

Optional Feature:
- Macro: BTB_STATS_EN.
- Defined:
  - three 32-bit counters, incremented when ready && exBranch:
    - statLookups on every resolved branch;
    - statHits when exPc hits;
    - statMispredicts when the prediction for exPc (hit && MSB) != exTaken, or when predicted taken with a stored target != exTarget.
  - Counters saturate at 32'hFFFF_FFFF.
  - Cleared by rst and by flush.
- Undefined: the stat ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package btb_pkg holds:
  - the btb_entry_t struct (valid, tag, target, counter), built from the module parameters;
  - the FSM state enum (IDLE, INIT);
  - the weakly-taken reset-counter helper function.
- Sub-module btb_sat_counter: a parametrised COUNTER_WIDTH saturating up/down counter (next-value logic). It is reused per update and by the stats block.

Test Plan:
- Init timing: rst low 2 cycles, then high; with SETS = 32, ready rises exactly 32 cycles later; fetchHit = 0 throughout.
- Allocate and hit: exBranch, exTaken = 1, exPc = 0x100, exTarget = 0x200. Next cycle fetchPc = 0x100 gives fetchHit = 1, fetchTarget = 0x200. One not-taken update then gives fetchHit = 0 (counter 10 to 01).
- Associativity: with WAYS = 2, three taken branches mapping to the same set (0x100, 0x100+4·SETS, 0x100+8·SETS).
  - The third evicts way 0 (the first branch).
  - The first branch then misses; the second and third hit.
- Target correction: entry 0x40 to 0x80, then taken update with exTarget = 0xC0; fetchTarget at 0x40 becomes 0xC0.
- Saturation: eight taken updates leave the counter at 11. Two not-taken updates give 01 and fetchHit = 0; a further three not-taken leave the counter at 00.
- Flush mid-INIT: flush asserted at walkIdx = 10 restarts the walk, so ready returns SETS cycles after flush. Entries allocated before the flush miss, and an exBranch during INIT leaves no entry.
  - With BTB_STATS_EN, all stat counters read 0 after the flush.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and helpers for the set-associative branch target buffer.
//
// Contents:
//   btb_entry_t  : one BTB entry (valid, tag, target, counter). The fields are
//                  sized for the widest legal configuration (30-bit tag, up to
//                  64-bit target, up to 4-bit counter). btb_set_assoc writes
//                  zero-extended values and compares whole fields, so the unused
//                  upper bits stay constant.
//   btb_state_t  : init-walker FSM state (IDLE, INIT).
//   weaklyTaken  : counter value 1 << (width-1) loaded on allocation.
package btb_pkg;

    localparam int unsigned BTB_MAX_TAG_WIDTH     = 30;
    localparam int unsigned BTB_MAX_TARGET_WIDTH  = 64;
    localparam int unsigned BTB_MAX_COUNTER_WIDTH = 4;

    typedef struct packed {
        logic                             valid;
        logic [BTB_MAX_TAG_WIDTH-1:0]     tag;
        logic [BTB_MAX_TARGET_WIDTH-1:0]  target;
        logic [BTB_MAX_COUNTER_WIDTH-1:0] counter;
    } btb_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        INIT = 1'b1
    } btb_state_t;

    function automatic logic [BTB_MAX_COUNTER_WIDTH-1:0] weaklyTaken(input int unsigned counterWidth);
        logic [BTB_MAX_COUNTER_WIDTH-1:0] value;
        value = '0;
        value[counterWidth-1] = 1'b1;
        return value;
    endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// Saturating up/down counter, next-value logic only (no state).
//
// Ports:
//   count : current counter value (WIDTH bits)
//   up    : 1 = increment, clamped at all-ones; 0 = decrement, clamped at zero
//   next  : resulting counter value
module btb_sat_counter #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up,
    output logic [WIDTH-1:0] next
);

    always_comb begin
        next = count;
        if (up) begin
            if (count != '1) begin
                next = count + 1'b1;
            end
        end else if (count != '0) begin
            next = count - 1'b1;
        end
    end

endmodule

// File: rtl/btb_set_assoc.sv
// N-way set-associative branch target buffer with per-entry saturating
// direction counters, round-robin victim selection per set, target correction
// on hit and a sequential init/flush walker.
//
// Ports:
//   clk             : clock
//   rst             : synchronous reset, active low
//   flush           : one-cycle pulse, invalidates the whole BTB via the walker
//   ready           : high when the init walker is idle
//   fetchPc         : fetch-stage PC (combinational lookup)
//   fetchHit        : predicted-taken hit (tag hit and counter MSB set)
//   fetchTarget     : hit way's target, 0 on a miss or while not ready
//   exBranch        : resolved branch valid this cycle
//   exTaken         : resolved direction
//   exPc            : PC of the resolved branch
//   exTarget        : resolved target
//   statLookups, statHits, statMispredicts : 32-bit saturating statistics,
//                     present only when the macro BTB_STATS_EN is defined.
//
// Addressing: index = PC[INDEX_WIDTH+1:2], tag = PC[31:INDEX_WIDTH+2].
module btb_set_assoc
    import btb_pkg::*;
#(
    parameter int BTB_ENTRIES   = 64,
    parameter int BTB_WAYS      = 2,
    parameter int TARGET_WIDTH  = 32,
    parameter int COUNTER_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    output logic                    ready,
    input  logic [31:0]             fetchPc,
    output logic                    fetchHit,
    output logic [TARGET_WIDTH-1:0] fetchTarget,
    input  logic                    exBranch,
    input  logic                    exTaken,
    input  logic [31:0]             exPc,
    input  logic [TARGET_WIDTH-1:0] exTarget
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]             statLookups,
    output logic [31:0]             statHits,
    output logic [31:0]             statMispredicts
`endif
);

    localparam int SETS        = BTB_ENTRIES / BTB_WAYS;
    localparam int INDEX_WIDTH = $clog2(SETS);
    localparam int TAG_WIDTH   = 30 - INDEX_WIDTH;
    localparam int IDX_W       = (INDEX_WIDTH > 0) ? INDEX_WIDTH : 1;
    localparam int WAY_W       = (BTB_WAYS > 1) ? $clog2(BTB_WAYS) : 1;
    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

    if (BTB_WAYS < 1 || BTB_WAYS > 8 || (BTB_WAYS & (BTB_WAYS - 1)) != 0) begin : gBadWays
        $error("btb_set_assoc: BTB_WAYS must be a power of two in 1..8");
    end
    if (BTB_ENTRIES < BTB_WAYS || (BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0) begin : gBadEntries
        $error("btb_set_assoc: BTB_ENTRIES must be a power of two and at least BTB_WAYS");
    end
    if (COUNTER_WIDTH < 1 || COUNTER_WIDTH > 4) begin : gBadCounter
        $error("btb_set_assoc: COUNTER_WIDTH must be in 1..4");
    end
    if (TARGET_WIDTH < 1 || TARGET_WIDTH > 64) begin : gBadTarget
        $error("btb_set_assoc: TARGET_WIDTH must be in 1..64");
    end

    // Storage: no reset, the walker clears valid bits and victim pointers.
    btb_entry_t       btbTable [SETS][BTB_WAYS];
    logic [WAY_W-1:0] rrPtr    [SETS];

    btb_state_t       state;
    logic [IDX_W-1:0] walkIdx;

    logic [IDX_W-1:0]     fetchIdx;
    logic [IDX_W-1:0]     exIdx;
    logic [TAG_WIDTH-1:0] fetchTag;
    logic [TAG_WIDTH-1:0] exTag;
    logic                 unusedPcBits;

    logic                     fetchTagHit;
    logic [WAY_W-1:0]         fetchWay;
    logic                     exHit;
    logic [WAY_W-1:0]         exWay;
    logic                     freeFound;
    logic [WAY_W-1:0]         freeWay;
    logic [WAY_W-1:0]         victimWay;
    logic [COUNTER_WIDTH-1:0] exCount;
    logic [COUNTER_WIDTH-1:0] ctrNext;
    logic                     exTargetDiff;

    if (INDEX_WIDTH > 0) begin : gIndex
        assign fetchIdx = fetchPc[INDEX_WIDTH+1:2];
        assign exIdx    = exPc[INDEX_WIDTH+1:2];
    end else begin : gNoIndex
        assign fetchIdx = '0;
        assign exIdx    = '0;
    end

    assign fetchTag     = fetchPc[31:INDEX_WIDTH+2];
    assign exTag        = exPc[31:INDEX_WIDTH+2];
    assign unusedPcBits = ^{fetchPc[1:0], exPc[1:0]};

    // Fetch lookup on pre-edge contents; lowest matching way wins.
    always_comb begin
        fetchTagHit = 1'b0;
        fetchWay    = '0;
        for (int unsigned w = 0; w < BTB_WAYS; w++) begin
            if (!fetchTagHit && btbTable[fetchIdx][w].valid &&
                btbTable[fetchIdx][w].tag == BTB_MAX_TAG_WIDTH'(fetchTag)) begin
                fetchTagHit = 1'b1;
                fetchWay    = WAY_W'(w);
            end
        end
    end

    always_comb begin
        fetchHit    = 1'b0;
        fetchTarget = '0;
        if (ready && fetchTagHit) begin
            fetchHit    = btbTable[fetchIdx][fetchWay].counter[COUNTER_WIDTH-1];
            fetchTarget = btbTable[fetchIdx][fetchWay].target[TARGET_WIDTH-1:0];
        end
    end

    // Execute-side lookup and victim choice: first invalid way, else the set's
    // round-robin pointer.
    always_comb begin
        exHit     = 1'b0;
        exWay     = '0;
        freeFound = 1'b0;
        freeWay   = '0;
        for (int unsigned w = 0; w < BTB_WAYS; w++) begin
            if (!exHit && btbTable[exIdx][w].valid &&
                btbTable[exIdx][w].tag == BTB_MAX_TAG_WIDTH'(exTag)) begin
                exHit = 1'b1;
                exWay = WAY_W'(w);
            end
            if (!freeFound && !btbTable[exIdx][w].valid) begin
                freeFound = 1'b1;
                freeWay   = WAY_W'(w);
            end
        end
        victimWay    = freeFound ? freeWay : rrPtr[exIdx];
        exCount      = btbTable[exIdx][exWay].counter[COUNTER_WIDTH-1:0];
        exTargetDiff = btbTable[exIdx][exWay].target != BTB_MAX_TARGET_WIDTH'(exTarget);
    end

    btb_sat_counter #(
        .WIDTH(COUNTER_WIDTH)
    ) uDirCounter (
        .count(exCount),
        .up   (exTaken),
        .next (ctrNext)
    );

    // Init walker: flush restarts the walk from set 0 in either state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= INIT;
            walkIdx <= '0;
            ready   <= 1'b0;
        end else if (flush) begin
            state   <= INIT;
            walkIdx <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (walkIdx == LAST_SET) begin
                        state   <= IDLE;
                        walkIdx <= '0;
                        ready   <= 1'b1;
                    end else begin
                        walkIdx <= walkIdx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            for (int unsigned w = 0; w < BTB_WAYS; w++) begin
                btbTable[walkIdx][w].valid <= 1'b0;
            end
            rrPtr[walkIdx] <= '0;
        end else if (rst && ready && exBranch) begin
            if (exHit) begin
                btbTable[exIdx][exWay].counter <= BTB_MAX_COUNTER_WIDTH'(ctrNext);
                if (exTaken && exTargetDiff) begin
                    btbTable[exIdx][exWay].target <= BTB_MAX_TARGET_WIDTH'(exTarget);
                end
            end else if (exTaken) begin
                btbTable[exIdx][victimWay].valid   <= 1'b1;
                btbTable[exIdx][victimWay].tag     <= BTB_MAX_TAG_WIDTH'(exTag);
                btbTable[exIdx][victimWay].target  <= BTB_MAX_TARGET_WIDTH'(exTarget);
                btbTable[exIdx][victimWay].counter <= weaklyTaken(COUNTER_WIDTH);
                // Pointer moves only when the way it names was consumed, even
                // if that way was picked for being invalid.
                if (BTB_WAYS > 1 && victimWay == rrPtr[exIdx]) begin
                    rrPtr[exIdx] <= rrPtr[exIdx] + 1'b1;
                end
            end
        end
    end

`ifdef BTB_STATS_EN
    logic        exPredTaken;
    logic        exMispredict;
    logic [31:0] lookupsNext;
    logic [31:0] hitsNext;
    logic [31:0] mispredictsNext;

    assign exPredTaken  = exHit && exCount[COUNTER_WIDTH-1];
    assign exMispredict = (exPredTaken != exTaken) || (exPredTaken && exTargetDiff);

    btb_sat_counter #(.WIDTH(32)) uStatLookups (
        .count(statLookups), .up(1'b1), .next(lookupsNext)
    );
    btb_sat_counter #(.WIDTH(32)) uStatHits (
        .count(statHits), .up(1'b1), .next(hitsNext)
    );
    btb_sat_counter #(.WIDTH(32)) uStatMispredicts (
        .count(statMispredicts), .up(1'b1), .next(mispredictsNext)
    );

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            statLookups     <= '0;
            statHits        <= '0;
            statMispredicts <= '0;
        end else if (ready && exBranch) begin
            statLookups <= lookupsNext;
            if (exHit) begin
                statHits <= hitsNext;
            end
            if (exMispredict) begin
                statMispredicts <= mispredictsNext;
            end
        end
    end
`endif

endmodule

// File: tb/tb_btb_set_assoc.sv
// Directed testbench for btb_set_assoc (default parameters: 64 entries,
// 2 ways, 32 sets). Expected values are pushed to a scoreboard queue when the
// stimulus is driven and popped when the DUT output is sampled.
// Define BTB_STATS_EN to also check the statistics counters.
`timescale 1ns/1ps
module tb_btb_set_assoc;

    localparam int SETS = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ready;
    logic [31:0] fetchPc;
    logic        fetchHit;
    logic [31:0] fetchTarget;
    logic        exBranch;
    logic        exTaken;
    logic [31:0] exPc;
    logic [31:0] exTarget;
`ifdef BTB_STATS_EN
    logic [31:0] statLookups;
    logic [31:0] statHits;
    logic [31:0] statMispredicts;
`endif

    always #5 clk = ~clk;

    btb_set_assoc #(
        .BTB_ENTRIES  (64),
        .BTB_WAYS     (2),
        .TARGET_WIDTH (32),
        .COUNTER_WIDTH(2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .ready          (ready),
        .fetchPc        (fetchPc),
        .fetchHit       (fetchHit),
        .fetchTarget    (fetchTarget),
        .exBranch       (exBranch),
        .exTaken        (exTaken),
        .exPc           (exPc),
        .exTarget       (exTarget)
`ifdef BTB_STATS_EN
        ,
        .statLookups    (statLookups),
        .statHits       (statHits),
        .statMispredicts(statMispredicts)
`endif
    );

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic pushExp(input string name, input logic [31:0] value);
        exp_t e;
        e.name  = name;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic popCheck(input logic [31:0] observed);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty: observed %0h", observed);
            return;
        end
        e = sb.pop_front();
        assert (observed === e.value) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", e.name, observed, e.value);
        end
    endtask

    task automatic checkNow(input string name, input logic [31:0] observed, input logic [31:0] expected);
        pushExp(name, expected);
        popCheck(observed);
    endtask

    task automatic lookup(input logic [31:0] pc, input logic expHit, input logic [31:0] expTgt,
                          input string name);
        @(negedge clk);
        fetchPc = pc;
        pushExp({name, ".hit"}, {31'd0, expHit});
        pushExp({name, ".target"}, expTgt);
        #1;
        popCheck({31'd0, fetchHit});
        popCheck(fetchTarget);
    endtask

    task automatic update(input logic taken, input logic [31:0] pc, input logic [31:0] tgt);
        @(negedge clk);
        exBranch = 1'b1;
        exTaken  = taken;
        exPc     = pc;
        exTarget = tgt;
        @(negedge clk);
        exBranch = 1'b0;
        exTaken  = 1'b0;
        exPc     = '0;
        exTarget = '0;
    endtask

    // Counts rising edges until ready is seen (bounded); also records any
    // non-zero fetch output observed while waiting.
    task automatic waitReady(output int cycles, output logic sawOutput);
        cycles    = 0;
        sawOutput = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            cycles = i;
            if (fetchHit !== 1'b0 || fetchTarget !== 32'd0) sawOutput = 1'b1;
            if (ready === 1'b1) break;
        end
    endtask

`ifdef BTB_STATS_EN
    task automatic checkStats(input logic [31:0] l, input logic [31:0] h, input logic [31:0] m,
                              input string name);
        checkNow({name, ".lookups"}, statLookups, l);
        checkNow({name, ".hits"}, statHits, h);
        checkNow({name, ".mispredicts"}, statMispredicts, m);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cycles;
        logic sawOutput;

        rst      = 1'b0;
        flush    = 1'b0;
        fetchPc  = 32'h100;
        exBranch = 1'b0;
        exTaken  = 1'b0;
        exPc     = '0;
        exTarget = '0;

        // Reset and init timing.
        repeat (2) @(posedge clk);
        #1;
        checkNow("reset.ready", {31'd0, ready}, 32'd0);
        checkNow("reset.fetchHit", {31'd0, fetchHit}, 32'd0);
`ifdef BTB_STATS_EN
        checkStats(0, 0, 0, "reset");
`endif
        @(negedge clk);
        rst = 1'b1;
        waitReady(cycles, sawOutput);
        checkNow("init.cycles", cycles, SETS);
        checkNow("init.quiet", {31'd0, sawOutput}, 32'd0);

        // Allocate, hit, then weaken below taken.
        update(1'b1, 32'h100, 32'h200);
        lookup(32'h100, 1'b1, 32'h200, "alloc");
        update(1'b0, 32'h100, 32'h0);
        lookup(32'h100, 1'b0, 32'h200, "weakened");

        // Three branches in set 0: the third evicts way 0.
        update(1'b1, 32'h180, 32'h1000);
        update(1'b1, 32'h200, 32'h2000);
        lookup(32'h100, 1'b0, 32'h0, "evicted");
        lookup(32'h180, 1'b1, 32'h1000, "way1");
        lookup(32'h200, 1'b1, 32'h2000, "way0new");

        // Target correction.
        update(1'b1, 32'h40, 32'h80);
        lookup(32'h40, 1'b1, 32'h80, "corr.before");
        update(1'b1, 32'h40, 32'hC0);
        lookup(32'h40, 1'b1, 32'hC0, "corr.after");

        // Saturation in both directions.
        repeat (8) update(1'b1, 32'h104, 32'h300);
        lookup(32'h104, 1'b1, 32'h300, "sat.high");
        update(1'b0, 32'h104, 32'h0);
        lookup(32'h104, 1'b1, 32'h300, "sat.nt1");
        update(1'b0, 32'h104, 32'h0);
        lookup(32'h104, 1'b0, 32'h300, "sat.nt2");
        repeat (3) update(1'b0, 32'h104, 32'h0);
        lookup(32'h104, 1'b0, 32'h300, "sat.low");
        update(1'b1, 32'h104, 32'h300);
        lookup(32'h104, 1'b0, 32'h300, "sat.up1");
        update(1'b1, 32'h104, 32'h300);
        lookup(32'h104, 1'b1, 32'h300, "sat.up2");

        // Not-taken miss allocates nothing; exBranch low ignores the rest.
        update(1'b0, 32'h108, 32'h500);
        lookup(32'h108, 1'b0, 32'h0, "ntmiss");
        @(negedge clk);
        exTaken  = 1'b1;
        exPc     = 32'h10C;
        exTarget = 32'h77;
        @(negedge clk);
        exTaken  = 1'b0;
        exPc     = '0;
        exTarget = '0;
        lookup(32'h10C, 1'b0, 32'h0, "nobranch");
`ifdef BTB_STATS_EN
        checkStats(22, 16, 11, "prefl");
`endif

        // Flush, then flush again at walkIdx = 10 with an exBranch during INIT.
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkNow("flush.ready", {31'd0, ready}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        checkNow("flush.midready", {31'd0, ready}, 32'd0);
        flush    = 1'b1;
        exBranch = 1'b1;
        exTaken  = 1'b1;
        exPc     = 32'h400;
        exTarget = 32'h900;
        @(posedge clk);
        #1;
        flush = 1'b0;
        waitReady(cycles, sawOutput);
        exBranch = 1'b0;
        exTaken  = 1'b0;
        exPc     = '0;
        exTarget = '0;
        checkNow("reflush.cycles", cycles, SETS);
        checkNow("reflush.quiet", {31'd0, sawOutput}, 32'd0);
`ifdef BTB_STATS_EN
        checkStats(0, 0, 0, "postfl");
`endif
        lookup(32'h180, 1'b0, 32'h0, "postfl.180");
        lookup(32'h200, 1'b0, 32'h0, "postfl.200");
        lookup(32'h40, 1'b0, 32'h0, "postfl.40");
        lookup(32'h104, 1'b0, 32'h0, "postfl.104");
        lookup(32'h400, 1'b0, 32'h0, "postfl.initdrop");

        update(1'b1, 32'h180, 32'h1800);
        lookup(32'h180, 1'b1, 32'h1800, "postfl.alloc");
`ifdef BTB_STATS_EN
        checkStats(1, 0, 1, "postfl.alloc");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
